sum_display_driver: RTL

Downstream consumer of the 4-bit behavioral adder/subtractor result: captures the 5-bit `sum` and the mode bit `m` on a load strobe. Converts the captured value to decimal with a sequential shift-add-3 (double-dabble) engine. Drives a 4-digit, common-anode seven-segment display by time-multiplexing the digits. Sits between the arithmetic stage and the board display pins.

---
 rtl/sum_display_pkg.sv | 16 +
 rtl/seg7_decoder.sv | 27 ++
 rtl/sum_display_driver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sum_display_pkg.sv
// rtl/sum_display_pkg.sv - shared constants and FSM state type for the sum display driver
package sum_display_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_MINUS  = 7'b0111111;
  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_MINUS = 4'd11;
  localparam int         NUM_DIGITS = 4;
  localparam int         BCD_ITERS  = 5;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - digit code to active-low seven-segment pattern (g..a)
module seg7_decoder
  import sum_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:       seg = 7'b1000000;
      4'd1:       seg = 7'b1111001;
      4'd2:       seg = 7'b0100100;
      4'd3:       seg = 7'b0110000;
      4'd4:       seg = 7'b0011001;
      4'd5:       seg = 7'b0010010;
      4'd6:       seg = 7'b0000010;
      4'd7:       seg = 7'b1111000;
      4'd8:       seg = 7'b0000000;
      4'd9:       seg = 7'b0010000;
      CODE_MINUS: seg = SEG_MINUS;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_display_driver.sv
// rtl/sum_display_driver.sv - captures adder result, converts to BCD, scans a 4-digit display
module sum_display_driver
  import sum_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       m,
  input  logic [4:0] sum,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_t      state, state_n;
  logic        capture, step, last;
  logic [2:0]  iter;
  logic        hold_m;
  logic [4:0]  hold_sum;
  logic [7:0]  bcd, bcd_adj, bcd_n;
  logic [4:0]  mag;
  logic        neg;
  logic [2:0]  bit_sel;
  logic        mag_bit;

  logic [3:0]    digit [NUM_DIGITS];
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic [6:0]    seg_dec;

  assign busy = (state == CONV);
  assign dp   = 1'b1;
  assign last = (iter == 3'(BCD_ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_n = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // In signed mode only the low nibble is meaningful; -8 negates to 4'b1000 = 8.
  always_comb begin
    neg = hold_m & hold_sum[3];
    mag = hold_sum;
    if (hold_m) begin
      if (hold_sum[3]) mag = {1'b0, (~hold_sum[3:0]) + 4'd1};
      else             mag = {1'b0, hold_sum[3:0]};
    end
  end

  // Magnitude bits enter MSB first, one per iteration.
  always_comb begin
    bit_sel = 3'(BCD_ITERS - 1) - iter;
    mag_bit = mag[bit_sel];
    bcd_adj = bcd;
    if (bcd_adj[3:0] >= 4'd5) bcd_adj[3:0] = bcd_adj[3:0] + 4'd3;
    if (bcd_adj[7:4] >= 4'd5) bcd_adj[7:4] = bcd_adj[7:4] + 4'd3;
    bcd_n = {bcd_adj[6:0], mag_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_m   <= 1'b0;
      hold_sum <= 5'd0;
      iter     <= 3'd0;
      bcd      <= 8'd0;
      digit[0] <= 4'd0;
      digit[1] <= CODE_BLANK;
      digit[2] <= CODE_BLANK;
      digit[3] <= CODE_BLANK;
    end else if (capture) begin
      hold_m   <= m;
      hold_sum <= sum;
      iter     <= 3'd0;
      bcd      <= 8'd0;
    end else if (step) begin
      iter <= iter + 3'd1;
      bcd  <= bcd_n;
      // All four digits change on the same edge so the scan never shows a mix.
      if (last) begin
        digit[0] <= bcd_n[3:0];
        digit[1] <= (bcd_n[7:4] == 4'd0) ? CODE_BLANK : bcd_n[7:4];
        digit[2] <= CODE_BLANK;
        digit[3] <= neg ? CODE_MINUS : CODE_BLANK;
      end
    end
  end

  seg7_decoder u_dec (
    .code (digit[idx]),
    .seg  (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
      an          <= 4'b1110;
      seg         <= 7'b1000000;
    end else begin
      if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_dec;
    end
  end

endmodule
